uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 75 +++++++
 tb/tb_uart_tx.sv | 96 +++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, one bit per CLK, optional even/odd parity
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                  state_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    pen_q, ptyp_q, tx_q, busy_q;
  // index of the data bit that goes out on the next edge
  always_comb cnt_d = cnt_q + 1'b1;
  // frame sequencer; TX_OUT/busy are registered and reflect the state being entered
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (Data_Valid) begin
          data_q  <= P_DATA;
          pen_q   <= PAR_EN;
          ptyp_q  <= PAR_TYP;
          state_q <= START;
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
        end
        START: begin
          state_q <= DATA;
          cnt_q   <= '0;
          tx_q    <= data_q[0];
        end
        DATA: if (cnt_q == LAST) begin
          cnt_q   <= '0;
          state_q <= pen_q ? PARITY : STOP;
          tx_q    <= pen_q ? (^data_q ^ ptyp_q) : 1'b1;
        end else begin
          cnt_q <= cnt_d;
          tx_q  <= data_q[cnt_d];
        end
        PARITY: begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
        STOP: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign TX_OUT = tx_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks for uart_tx
module tb_uart_tx;
  logic       CLK = 1'b0;
  logic       RST, Data_Valid, PAR_EN, PAR_TYP;
  logic [7:0] P_DATA;
  logic       TX_OUT, busy;
  int         total = 0, bad = 0;
  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .busy(busy)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic go(input logic [7:0] d, input logic pe, input logic pt);
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    Data_Valid = 1'b1;
  endtask
  // mode 0: one-cycle request, 1: request held (next word = ~d), 2: disturb inputs mid-frame
  task automatic frame(input string tag, input logic [7:0] d, input logic pe, input logic ep, input int mode);
    logic [11:0] got, exp;
    int n, bc;
    n = pe ? 11 : 10;
    bc = 0;
    got = '0;
    exp = pe ? {1'b0, 1'b1, ep, d, 1'b0} : {2'b00, 1'b1, d, 1'b0};
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      got[i] = TX_OUT;
      if (busy) bc++;
      if (i == 0 && mode != 1) Data_Valid = 1'b0;
      if (i == 1 && mode == 1) P_DATA = ~d;
      if (i == 3 && mode == 2) begin
        P_DATA = 8'h00;
        PAR_EN = 1'b1;
        Data_Valid = 1'b1;
      end
      if (i == 4 && mode == 2) Data_Valid = 1'b0;
    end
    check({tag, "_bits"}, 16'(got), 16'(exp));
    check({tag, "_len"}, 16'(bc), 16'(n));
    @(negedge CLK);
    check({tag, "_idle"}, {14'd0, TX_OUT, busy}, 16'h2);
  endtask
  initial begin
    RST = 1'b1;
    Data_Valid = 1'b0;
    P_DATA = 8'h00;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    #1 RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset", {14'd0, TX_OUT, busy}, 16'h2);
    go(8'hA5, 1'b0, 1'b0);
    RST = 1'b1;
    frame("a5", 8'hA5, 1'b0, 1'b0, 0);
    go(8'hA5, 1'b1, 1'b0);
    frame("a5_even", 8'hA5, 1'b1, 1'b0, 0);
    go(8'hA5, 1'b1, 1'b1);
    frame("a5_odd", 8'hA5, 1'b1, 1'b1, 0);
    go(8'h01, 1'b1, 1'b0);
    frame("01_even", 8'h01, 1'b1, 1'b1, 0);
    go(8'h00, 1'b1, 1'b1);
    frame("00_odd", 8'h00, 1'b1, 1'b1, 0);
    go(8'hFF, 1'b0, 1'b0);
    frame("ff_glitch", 8'hFF, 1'b0, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("ff_no_second", {15'd0, busy}, 16'h0);
    end
    go(8'h3C, 1'b0, 1'b0);
    frame("b2b_3c", 8'h3C, 1'b0, 1'b0, 1);
    frame("b2b_c3", 8'hC3, 1'b0, 1'b0, 0);
    go(8'hA5, 1'b0, 1'b0);
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    check("pre_reset_bit3", {14'd0, TX_OUT, busy}, 16'h1);
    #2 RST = 1'b0;
    #1 check("async_reset", {14'd0, TX_OUT, busy}, 16'h2);
    @(negedge CLK);
    check("held_reset", {14'd0, TX_OUT, busy}, 16'h2);
    go(8'h5A, 1'b1, 1'b1);
    RST = 1'b1;
    frame("post_reset", 8'h5A, 1'b1, 1'b1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
